// File: rtl/noc_msg_pkg.sv
// -----------------------------------------------------------------------------
// noc_msg_pkg
// Shared definitions for the NoC message deserializer: flit width, header
// field positions, header field extraction helpers and the FSM state encoding.
// -----------------------------------------------------------------------------
package noc_msg_pkg;

    localparam int FLIT_W      = 64;
    localparam int LEN_HI      = 29;
    localparam int LEN_LO      = 22;
    localparam int MSG_TYPE_HI = 21;
    localparam int MSG_TYPE_LO = 14;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BODY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Payload length (in flits) carried by a header flit.
    function automatic logic [7:0] hdr_len(input logic [FLIT_W-1:0] hdr);
        return hdr[LEN_HI:LEN_LO];
    endfunction

    // Message type carried by a header flit.
    function automatic logic [7:0] hdr_msg_type(input logic [FLIT_W-1:0] hdr);
        return hdr[MSG_TYPE_HI:MSG_TYPE_LO];
    endfunction

endpackage

// File: rtl/noc_msg_payload_buf.sv
// -----------------------------------------------------------------------------
// noc_msg_payload_buf
// MAX_PAYLOAD x FLIT_W payload store with a synchronous clear, an indexed
// write port and a flat read port.
//   clk      in   clock
//   rst      in   asynchronous active-high reset, clears every slot
//   clr      in   clear every slot (takes priority over a write)
//   wr_en    in   write wr_data into slot wr_idx
//   wr_idx   in   slot index; indices >= MAX_PAYLOAD never match a slot
//   wr_data  in   flit to store
//   rd_data  out  slot k at bits [k*FLIT_W +: FLIT_W]
// -----------------------------------------------------------------------------
module noc_msg_payload_buf
    import noc_msg_pkg::*;
#(
    parameter int MAX_PAYLOAD = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clr,
    input  logic                          wr_en,
    input  logic [7:0]                    wr_idx,
    input  logic [FLIT_W-1:0]             wr_data,
    output logic [MAX_PAYLOAD*FLIT_W-1:0] rd_data
);

    // NOTE: this array is reset because the payload output is architecturally
    // visible and must read as zero after reset; a pure datapath store that is
    // never read before being written would normally be left unreset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (clr) begin
            rd_data <= '0;
        end else if (wr_en) begin
            // Decoding per slot keeps an 8-bit index from ever aliasing into
            // a valid slot when it exceeds the array size.
            for (int k = 0; k < MAX_PAYLOAD; k++) begin
                if (wr_idx == 8'(k)) begin
                    rd_data[k*FLIT_W +: FLIT_W] <= wr_data;
                end
            end
        end
    end

endmodule

// File: rtl/noc_msg_deserializer.sv
// -----------------------------------------------------------------------------
// noc_msg_deserializer
// Receive-side NoC endpoint: accepts a header flit plus the payload flits it
// announces and presents the whole message as one parallel word behind a
// valid/ready handshake. One message buffer, no bypass.
//   clk           in   clock
//   rst           in   asynchronous active-high reset
//   noc_in_val    in   flit valid
//   noc_in_data   in   flit data
//   noc_in_rdy    out  registered; flit accepted when noc_in_val & noc_in_rdy
//   msg_val       out  assembled message available
//   msg_rdy       in   consumer accepts the message
//   msg_header    out  captured header flit
//   msg_len       out  header length field
//   msg_payload   out  payload flit k at bits [k*FLIT_W +: FLIT_W]
//   msg_oversize  out  header length exceeded MAX_PAYLOAD; excess dropped
//   err_count     out  saturating count of oversize messages
// -----------------------------------------------------------------------------
module noc_msg_deserializer
    import noc_msg_pkg::*;
#(
    parameter int MAX_PAYLOAD = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          noc_in_val,
    input  logic [FLIT_W-1:0]             noc_in_data,
    output logic                          noc_in_rdy,
    output logic                          msg_val,
    input  logic                          msg_rdy,
    output logic [FLIT_W-1:0]             msg_header,
    output logic [7:0]                    msg_len,
    output logic [MAX_PAYLOAD*FLIT_W-1:0] msg_payload,
    output logic                          msg_oversize,
    output logic [15:0]                   err_count
);

    localparam logic [7:0] MAX_PAYLOAD_B = 8'(MAX_PAYLOAD);

    state_t     state, state_next;
    logic       rdy_q;
    logic [7:0] idx_q, remaining_q;
    logic       flit_xfer, msg_xfer;
    logic       hdr_capture, buf_we;
    logic [7:0] in_len;

    assign in_len     = hdr_len(noc_in_data);
    assign flit_xfer  = noc_in_val & rdy_q;
    assign msg_val    = (state == DONE);
    assign msg_xfer   = msg_val & msg_rdy;
    assign noc_in_rdy = rdy_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: every signal driven here gets a default first so no path through
    // the case leaves it unassigned, which would infer a latch.
    always_comb begin
        state_next  = state;
        hdr_capture = 1'b0;
        buf_we      = 1'b0;
        unique case (state)
            IDLE: begin
                if (flit_xfer) begin
                    hdr_capture = 1'b1;
                    state_next  = (in_len == 8'd0) ? DONE : BODY;
                end
            end
            BODY: begin
                if (flit_xfer) begin
                    // Flits beyond the buffer are still consumed, just not stored.
                    buf_we = (idx_q < MAX_PAYLOAD_B);
                    if (remaining_q == 8'd1) state_next = DONE;
                end
            end
            DONE: begin
                if (msg_rdy) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Ready is derived from the next state so it is a clean register output:
    // it drops on the same edge msg_val rises and returns the edge after the
    // message handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy_q        <= 1'b0;
            idx_q        <= '0;
            remaining_q  <= '0;
            msg_header   <= '0;
            msg_len      <= '0;
            msg_oversize <= 1'b0;
            err_count    <= '0;
        end else begin
            rdy_q <= (state_next != DONE);
            if (hdr_capture) begin
                msg_header   <= noc_in_data;
                msg_len      <= in_len;
                msg_oversize <= (in_len > MAX_PAYLOAD_B);
                idx_q        <= '0;
                remaining_q  <= in_len;
            end else if (state == BODY && flit_xfer) begin
                // idx tops out at len-1 <= 254, so the increment cannot wrap.
                idx_q       <= idx_q + 8'd1;
                remaining_q <= remaining_q - 8'd1;
            end
            if (msg_xfer && msg_oversize && err_count != 16'hFFFF) begin
                err_count <= err_count + 16'd1;
            end
        end
    end

    noc_msg_payload_buf #(
        .MAX_PAYLOAD (MAX_PAYLOAD)
    ) u_payload_buf (
        .clk     (clk),
        .rst     (rst),
        .clr     (hdr_capture),
        .wr_en   (buf_we),
        .wr_idx  (idx_q),
        .wr_data (noc_in_data),
        .rd_data (msg_payload)
    );

endmodule

// File: tb/tb_noc_msg_deserializer.sv
// -----------------------------------------------------------------------------
// tb_noc_msg_deserializer
// Directed self-checking bench for noc_msg_deserializer. Inputs change and
// outputs are sampled 1 ns after each rising edge.
// -----------------------------------------------------------------------------
module tb_noc_msg_deserializer;

    localparam int FW = 64;
    localparam int MP = 8;

    logic              clk;
    logic              rst;
    logic              noc_in_val;
    logic [FW-1:0]     noc_in_data;
    logic              noc_in_rdy;
    logic              msg_val;
    logic              msg_rdy;
    logic [FW-1:0]     msg_header;
    logic [7:0]        msg_len;
    logic [MP*FW-1:0]  msg_payload;
    logic              msg_oversize;
    logic [15:0]       err_count;

    int checks = 0;
    int errors = 0;

    noc_msg_deserializer #(.MAX_PAYLOAD(MP)) dut (
        .clk          (clk),
        .rst          (rst),
        .noc_in_val   (noc_in_val),
        .noc_in_data  (noc_in_data),
        .noc_in_rdy   (noc_in_rdy),
        .msg_val      (msg_val),
        .msg_rdy      (msg_rdy),
        .msg_header   (msg_header),
        .msg_len      (msg_len),
        .msg_payload  (msg_payload),
        .msg_oversize (msg_oversize),
        .err_count    (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Header: 16'hCAFE tag, len in [29:22], msg type in [21:14].
    function automatic logic [63:0] mk_hdr(input logic [7:0] len, input logic [7:0] mtype);
        return {16'hCAFE, 18'h0, len, mtype, 14'h0};
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, "_rdy"},      512'(noc_in_rdy),   512'(0));
        check({tag, "_val"},      512'(msg_val),      512'(0));
        check({tag, "_hdr"},      512'(msg_header),   512'(0));
        check({tag, "_len"},      512'(msg_len),      512'(0));
        check({tag, "_payload"},  512'(msg_payload),  512'(0));
        check({tag, "_oversize"}, 512'(msg_oversize), 512'(0));
        check({tag, "_err"},      512'(err_count),    512'(0));
    endtask

    logic [63:0]  hdr;
    logic [511:0] exp_p;
    logic [511:0] held_p;

    initial begin
        rst         = 1'b1;
        noc_in_val  = 1'b0;
        noc_in_data = '0;
        msg_rdy     = 1'b0;
        tick();
        tick();
        check_reset_values("reset");

        rst = 1'b0;
        tick();
        check("rdy_after_reset", 512'(noc_in_rdy), 512'(1));
        check("val_after_reset", 512'(msg_val), 512'(0));

        // ---------------- zero-length message ----------------
        msg_rdy     = 1'b1;
        noc_in_val  = 1'b1;
        noc_in_data = 64'h0;
        tick();
        noc_in_val = 1'b0;
        check("zl_val",     512'(msg_val),     512'(1));
        check("zl_rdy",     512'(noc_in_rdy),  512'(0));
        check("zl_len",     512'(msg_len),     512'(0));
        check("zl_payload", 512'(msg_payload), 512'(0));
        tick();
        check("zl_val_drop", 512'(msg_val),    512'(0));
        check("zl_rdy_back", 512'(noc_in_rdy), 512'(1));
        check("zl_err",      512'(err_count),  512'(0));

        // ---------------- three-flit payload ----------------
        hdr = mk_hdr(8'd3, 8'h11);
        noc_in_val = 1'b1; noc_in_data = hdr;   tick();
        check("p3_hdr", 512'(msg_header), 512'(hdr));
        noc_in_data = 64'hA1;                   tick();
        noc_in_data = 64'hA2;                   tick();
        check("p3_val_early", 512'(msg_val), 512'(0));
        noc_in_data = 64'hA3;                   tick();
        noc_in_val = 1'b0;
        exp_p = '0;
        exp_p[63:0]    = 64'hA1;
        exp_p[127:64]  = 64'hA2;
        exp_p[191:128] = 64'hA3;
        check("p3_val",      512'(msg_val),      512'(1));
        check("p3_len",      512'(msg_len),      512'(3));
        check("p3_payload",  512'(msg_payload),  exp_p);
        check("p3_oversize", 512'(msg_oversize), 512'(0));
        tick();
        check("p3_val_drop", 512'(msg_val), 512'(0));

        // ---------------- backpressure ----------------
        msg_rdy = 1'b0;
        noc_in_val = 1'b1; noc_in_data = hdr;   tick();
        noc_in_data = 64'hA1;                   tick();
        noc_in_data = 64'hA2;                   tick();
        noc_in_data = 64'hA3;                   tick();
        check("bp_val", 512'(msg_val), 512'(1));
        held_p = exp_p;
        hdr = mk_hdr(8'd1, 8'h22);
        noc_in_data = hdr;                      // new header waits on the input
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("bp_rdy_%0d", i),     512'(noc_in_rdy),  512'(0));
            check($sformatf("bp_val_%0d", i),     512'(msg_val),     512'(1));
            check($sformatf("bp_payload_%0d", i), 512'(msg_payload), held_p);
            check($sformatf("bp_hdr_%0d", i),     512'(msg_header),  512'(mk_hdr(8'd3, 8'h11)));
        end
        msg_rdy = 1'b1;
        tick();
        check("bp_handshake_val", 512'(msg_val),    512'(0));
        check("bp_handshake_rdy", 512'(noc_in_rdy), 512'(1));
        check("bp_hdr_not_taken", 512'(msg_header), 512'(mk_hdr(8'd3, 8'h11)));
        tick();
        check("bp_new_hdr", 512'(msg_header), 512'(hdr));
        check("bp_new_len", 512'(msg_len),    512'(1));
        noc_in_data = 64'hB1;                   tick();
        noc_in_val = 1'b0;
        exp_p = '0;
        exp_p[63:0] = 64'hB1;
        check("bp_new_val",     512'(msg_val),     512'(1));
        check("bp_new_payload", 512'(msg_payload), exp_p);
        tick();
        check("bp_new_drop", 512'(msg_val), 512'(0));

        // ---------------- oversize ----------------
        msg_rdy = 1'b0;
        hdr = mk_hdr(8'd10, 8'h33);
        noc_in_val = 1'b1; noc_in_data = hdr;   tick();
        for (int i = 1; i <= 10; i++) begin
            check($sformatf("ov_val_before_%0d", i), 512'(msg_val), 512'(0));
            noc_in_data = 64'(i);
            tick();
        end
        noc_in_val = 1'b0;
        exp_p = '0;
        for (int i = 0; i < MP; i++) exp_p[i*FW +: FW] = 64'(i + 1);
        check("ov_val",      512'(msg_val),      512'(1));
        check("ov_len",      512'(msg_len),      512'(10));
        check("ov_payload",  512'(msg_payload),  exp_p);
        check("ov_oversize", 512'(msg_oversize), 512'(1));
        check("ov_err_pre",  512'(err_count),    512'(0));
        msg_rdy = 1'b1;
        tick();
        check("ov_err_post", 512'(err_count), 512'(1));
        check("ov_val_drop", 512'(msg_val),   512'(0));

        // ---------------- gapped input ----------------
        msg_rdy = 1'b0;
        hdr = mk_hdr(8'd2, 8'h44);
        noc_in_val = 1'b1; noc_in_data = hdr;    tick();
        noc_in_data = 64'hC1;                    tick();
        noc_in_val = 1'b0; noc_in_data = 64'hDEAD; tick();
        tick();
        check("gap_val_stall", 512'(msg_val),    512'(0));
        check("gap_rdy_stall", 512'(noc_in_rdy), 512'(1));
        noc_in_val = 1'b1; noc_in_data = 64'hC2; tick();
        noc_in_val = 1'b0;
        exp_p = '0;
        exp_p[63:0]   = 64'hC1;
        exp_p[127:64] = 64'hC2;
        check("gap_val",      512'(msg_val),      512'(1));
        check("gap_payload",  512'(msg_payload),  exp_p);
        check("gap_oversize", 512'(msg_oversize), 512'(0));
        msg_rdy = 1'b1;
        tick();
        check("gap_err", 512'(err_count), 512'(1));

        // ---------------- mid-message reset ----------------
        hdr = mk_hdr(8'd4, 8'h55);
        noc_in_val = 1'b1; noc_in_data = hdr;   tick();
        noc_in_data = 64'hD1;                   tick();
        rst = 1'b1;
        #1;
        check_reset_values("midrst");
        noc_in_val = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        check("midrst_rdy_back", 512'(noc_in_rdy), 512'(1));
        hdr = mk_hdr(8'd1, 8'h66);
        noc_in_val = 1'b1; noc_in_data = hdr;   tick();
        noc_in_data = 64'hE1;                   tick();
        noc_in_val = 1'b0;
        exp_p = '0;
        exp_p[63:0] = 64'hE1;
        check("post_val",     512'(msg_val),     512'(1));
        check("post_hdr",     512'(msg_header),  512'(hdr));
        check("post_len",     512'(msg_len),     512'(1));
        check("post_payload", 512'(msg_payload), exp_p);
        tick();
        check("post_val_drop", 512'(msg_val),   512'(0));
        check("post_err",      512'(err_count), 512'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
